// File: rtl/apb_pkg.sv
// Shared constants and FSM state type for the two-slave APB bridge.
// Optional wait-state slaves are enabled with `define APB_WAIT_STATE_EN.
package apb_pkg;

    localparam int AW      = 9;
    localparam int DW      = 8;
    localparam int IW      = AW - 1;
    localparam int DEPTH   = 2 ** IW;
    localparam int SEL_BIT = AW - 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_slave_mem.sv
// Memory-backed APB slave; read data is combinational while selected.
// Build with `define APB_WAIT_STATE_EN to insert one wait state per transfer.
module apb_slave_mem
    import apb_pkg::*;
(
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [IW-1:0] PADDR,
    input  logic [DW-1:0] PWDATA,
    output logic [DW-1:0] PRDATA,
    output logic          PREADY
);

    logic [DW-1:0] mem [DEPTH];
    logic          access;

    assign access = PSEL & PENABLE;

`ifdef APB_WAIT_STATE_EN
    logic waited;

    // Low for the first ACCESS cycle, high for the second, then rearms.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            waited <= 1'b0;
        end else if (access) begin
            waited <= ~waited;
        end
    end

    assign PREADY = waited;
`else
    assign PREADY = 1'b1;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (access && PWRITE && PREADY) begin
            mem[PADDR] <= PWDATA;
        end
    end

    assign PRDATA = PSEL ? mem[PADDR] : '0;

endmodule

// File: rtl/apb_modport.sv
// APB master FSM driving two memory slaves from a simple transfer request.
// Slaves honour `define APB_WAIT_STATE_EN (one wait state per transfer).
module apb_modport
    import apb_pkg::*;
(
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          transfer,
    input  logic          READ_WRITE,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [AW-1:0] apb_read_paddr,
    input  logic [DW-1:0] apb_write_data,
    output logic [DW-1:0] apb_read_data_out
);

    apb_state_t    state;
    apb_state_t    state_nxt;
    logic          load;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pready;
    logic          pready1;
    logic          pready2;
    logic [DW-1:0] prdata;
    logic [DW-1:0] prdata1;
    logic [DW-1:0] prdata2;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (transfer) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    if (transfer) begin
                        state_nxt = SETUP;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        psel1   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        if (state != IDLE) begin
            psel1 = ~paddr[SEL_BIT];
            psel2 = paddr[SEL_BIT];
        end
        if (state == ACCESS) begin
            penable = 1'b1;
        end
    end

    assign pready = psel2 ? pready2 : pready1;
    assign prdata = psel2 ? prdata2 : prdata1;

    // Request fields are captured on entry to SETUP and held to completion.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state             <= IDLE;
            pwrite            <= 1'b0;
            paddr             <= '0;
            pwdata            <= '0;
            apb_read_data_out <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                pwrite <= ~READ_WRITE;
                paddr  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
                pwdata <= apb_write_data;
            end
            if (penable && pready && !pwrite) begin
                apb_read_data_out <= prdata;
            end
        end
    end

    apb_slave_mem u_slave1 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (psel1),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr[IW-1:0]),
        .PWDATA  (pwdata),
        .PRDATA  (prdata1),
        .PREADY  (pready1)
    );

    apb_slave_mem u_slave2 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (psel2),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr[IW-1:0]),
        .PWDATA  (pwdata),
        .PRDATA  (prdata2),
        .PREADY  (pready2)
    );

endmodule

// File: tb/tb_apb_modport.sv
// Randomized self-checking bench for apb_modport against a flat-memory model.
// Expected timing follows `define APB_WAIT_STATE_EN when set.
module tb_apb_modport;

`ifdef APB_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    typedef struct {
        bit         rd;
        logic [8:0] a;
        logic [7:0] d;
    } op_t;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       transfer;
    logic       READ_WRITE;
    logic [8:0] apb_write_paddr;
    logic [8:0] apb_read_paddr;
    logic [7:0] apb_write_data;
    logic [7:0] apb_read_data_out;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] ref_mem [512];
    logic [7:0] ref_rd;

    always #5 PCLK = ~PCLK;

    apb_modport dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_read_paddr    (apb_read_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_data_out (apb_read_data_out)
    );

    task automatic ref_reset();
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        ref_rd = 8'h00;
    endtask

    task automatic ref_apply(input bit rd, input logic [8:0] a,
                             input logic [7:0] d);
        if (rd) ref_rd = ref_mem[a];
        else ref_mem[a] = d;
    endtask

    task automatic drive(input bit rd, input logic [8:0] a,
                         input logic [7:0] d);
        transfer        = 1'b1;
        READ_WRITE      = rd;
        apb_read_paddr  = rd ? a : 9'($urandom);
        apb_write_paddr = rd ? 9'($urandom) : a;
        apb_write_data  = rd ? 8'($urandom) : d;
    endtask

    // One isolated transfer; mid = output one cycle before expected completion.
    task automatic single(input bit rd, input logic [8:0] a,
                          input logic [7:0] d, output logic [7:0] mid);
        @(negedge PCLK);
        drive(rd, a, d);
        @(posedge PCLK);
        @(negedge PCLK);
        transfer        = 1'b0;
        READ_WRITE      = 1'($urandom);
        apb_read_paddr  = 9'($urandom);
        apb_write_paddr = 9'($urandom);
        apb_write_data  = 8'($urandom);
        repeat (1 + WS) @(posedge PCLK);
        @(negedge PCLK);
        mid = apb_read_data_out;
        @(posedge PCLK);
        ref_apply(rd, a, d);
        @(negedge PCLK);
    endtask

    // Transfers with transfer held high; got[k]/exp[k] after op k completes.
    task automatic burst(input op_t ops[16], input int n,
                         output logic [7:0] got[16],
                         output logic [7:0] exp[16]);
        @(negedge PCLK);
        drive(ops[0].rd, ops[0].a, ops[0].d);
        @(posedge PCLK);
        for (int k = 0; k < n; k++) begin
            @(negedge PCLK);
            if (k > 0) got[k-1] = apb_read_data_out;
            if (k < n - 1) drive(ops[k+1].rd, ops[k+1].a, ops[k+1].d);
            else transfer = 1'b0;
            repeat (2 + WS) @(posedge PCLK);
            ref_apply(ops[k].rd, ops[k].a, ops[k].d);
            exp[k] = ref_rd;
        end
        @(negedge PCLK);
        got[n-1] = apb_read_data_out;
    endtask

    task automatic test_reset();
        logic [7:0] mid;
        logic [8:0] addrs [3];
        PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b0;
        ref_reset();
        n_total++;
        if (apb_read_data_out !== 8'h00)
            $display("FAIL reset_rdata got %h want 00", apb_read_data_out);
        else n_pass++;
        addrs[0] = 9'h000;
        addrs[1] = 9'h1FF;
        addrs[2] = 9'($urandom);
        for (int i = 0; i < 3; i++) begin
            single(1'b1, addrs[i], 8'h00, mid);
            n_total++;
            if (apb_read_data_out !== ref_rd)
                $display("FAIL reset_read[%h] got %h want %h",
                         addrs[i], apb_read_data_out, ref_rd);
            else n_pass++;
        end
    endtask

    task automatic test_single_rw();
        logic [7:0] mid;
        logic [7:0] old;
        single(1'b0, 9'h005, 8'hA5, mid);
        n_total++;
        if (apb_read_data_out !== 8'h00)
            $display("FAIL write_keeps_rdata got %h want 00",
                     apb_read_data_out);
        else n_pass++;
        old = ref_rd;
        single(1'b1, 9'h005, 8'h00, mid);
        n_total++;
        if (mid !== old)
            $display("FAIL read_latency_early got %h want %h", mid, old);
        else n_pass++;
        n_total++;
        if (apb_read_data_out !== 8'hA5)
            $display("FAIL single_read got %h want a5", apb_read_data_out);
        else n_pass++;
    endtask

    task automatic test_isolation();
        logic [7:0] mid;
        single(1'b0, 9'h010, 8'h11, mid);
        single(1'b0, 9'h110, 8'h22, mid);
        single(1'b1, 9'h010, 8'h00, mid);
        n_total++;
        if (apb_read_data_out !== 8'h11)
            $display("FAIL iso_slave1 got %h want 11", apb_read_data_out);
        else n_pass++;
        single(1'b1, 9'h110, 8'h00, mid);
        n_total++;
        if (apb_read_data_out !== 8'h22)
            $display("FAIL iso_slave2 got %h want 22", apb_read_data_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        op_t        ops [16];
        logic [7:0] got [16];
        logic [7:0] exp [16];
        logic [8:0] a4 [4];
        logic [7:0] d4 [4];
        a4[0] = 9'h0FF; d4[0] = 8'hFF;
        a4[1] = 9'h1FF; d4[1] = 8'h01;
        a4[2] = 9'h000; d4[2] = 8'h3C;
        a4[3] = 9'h100; d4[3] = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            ops[i]     = '{rd: 1'b0, a: a4[i], d: d4[i]};
            ops[i + 4] = '{rd: 1'b1, a: a4[i], d: 8'h00};
        end
        burst(ops, 8, got, exp);
        for (int k = 0; k < 8; k++) begin
            n_total++;
            if (got[k] !== exp[k])
                $display("FAIL b2b[%0d] got %h want %h", k, got[k], exp[k]);
            else n_pass++;
        end
        n_total++;
        if (got[7] !== 8'hC3)
            $display("FAIL b2b_last got %h want c3", got[7]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] mid;
        single(1'b1, 9'h0FF, 8'h00, mid);
        n_total++;
        if (apb_read_data_out !== 8'hFF)
            $display("FAIL pre_reset_read got %h want ff", apb_read_data_out);
        else n_pass++;
        @(negedge PCLK);
        drive(1'b0, 9'h020, 8'h5A);
        @(posedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b0;
        ref_reset();
        n_total++;
        if (apb_read_data_out !== 8'h00)
            $display("FAIL mid_reset_rdata got %h want 00", apb_read_data_out);
        else n_pass++;
        single(1'b1, 9'h020, 8'h00, mid);
        n_total++;
        if (apb_read_data_out !== 8'h00)
            $display("FAIL aborted_write got %h want 00", apb_read_data_out);
        else n_pass++;
        single(1'b1, 9'h0FF, 8'h00, mid);
        n_total++;
        if (apb_read_data_out !== 8'h00)
            $display("FAIL mem_cleared got %h want 00", apb_read_data_out);
        else n_pass++;
    endtask

    function automatic logic [8:0] pick_addr();
        logic [8:0] pool [8];
        pool[0] = 9'h000; pool[1] = 9'h001; pool[2] = 9'h07F;
        pool[3] = 9'h080; pool[4] = 9'h0FF; pool[5] = 9'h100;
        pool[6] = 9'h17F; pool[7] = 9'h1FF;
        if ($urandom_range(0, 3) == 0) return 9'($urandom);
        return pool[$urandom_range(0, 7)];
    endfunction

    task automatic test_random();
        logic [7:0] mid;
        logic [7:0] old;
        bit         rd;
        logic [8:0] a;
        logic [7:0] d;
        op_t        ops [16];
        logic [7:0] got [16];
        logic [7:0] exp [16];
        for (int i = 0; i < 40; i++) begin
            rd  = 1'($urandom);
            a   = pick_addr();
            d   = 8'($urandom);
            old = ref_rd;
            single(rd, a, d, mid);
            n_total++;
            if (mid !== old)
                $display("FAIL rnd_early[%0d] got %h want %h", i, mid, old);
            else n_pass++;
            n_total++;
            if (apb_read_data_out !== ref_rd)
                $display("FAIL rnd_single[%0d] a=%h got %h want %h",
                         i, a, apb_read_data_out, ref_rd);
            else n_pass++;
        end
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 12; k++) begin
                ops[k] = '{rd: 1'($urandom), a: pick_addr(),
                           d: 8'($urandom)};
            end
            burst(ops, 12, got, exp);
            for (int k = 0; k < 12; k++) begin
                n_total++;
                if (got[k] !== exp[k])
                    $display("FAIL rnd_b2b[%0d][%0d] got %h want %h",
                             b, k, got[k], exp[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        PRESETn         = 1'b1;
        transfer        = 1'b0;
        READ_WRITE      = 1'b0;
        apb_write_paddr = 9'h000;
        apb_read_paddr  = 9'h000;
        apb_write_data  = 8'h00;
        ref_reset();
        test_reset();
        test_single_rw();
        test_isolation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
